// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: RISC-V load/store funct3 encodings, the controller state enum,
// and request classification helpers (illegal funct3, natural alignment).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } lsu_state_t;

    // Stores only exist for B/H/W; loads have no 011/110/111 encodings.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we) return funct3 > F3_W;
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    // funct3[1:0] encodes the access size for every legal encoding.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension.
// Ports:
//   funct3 - load funct3 selecting byte/half/word and signed/unsigned
//   raw    - right-justified load data (byte in [7:0], half in [15:0])
//   data   - sign- or zero-extended result; words pass through
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   data = {24'h0, raw[7:0]};
            F3_HU:   data = {16'h0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller between a core request port and a data memory.
// Aligned accesses take one memory cycle; misaligned ones are either split
// into byte accesses (MISALIGN_SPLIT=1) or rejected with rsp_err.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req_valid/req_ready     - request handshake (ready only when idle)
//   req_we, req_funct3      - store/load select and RISC-V funct3
//   req_addr, req_wdata     - byte address and store data
//   rsp_valid               - one-cycle completion pulse
//   rsp_rdata, rsp_err      - extended load data / error flag
//   mem_read, mem_write     - data-memory strobes (never both)
//   mem_funct3, mem_addr,
//   mem_wdata               - data-memory command
//   mem_rdata               - combinational memory read data, addressed
//                             bytes right-justified
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_n;
    logic        we_q, err_q, done_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  cnt;

    logic        req_bad, req_aligned, last_byte;
    logic [31:0] ext_raw, ext_data, split_wdata;

    assign req_aligned = is_aligned(req_funct3, req_addr[1:0]);
    assign req_bad     = is_illegal(req_we, req_funct3) ||
                         ((MISALIGN_SPLIT == 0) && !req_aligned);

    // Half splits stop after byte 1, word splits after byte 3.
    assign last_byte   = (cnt == ((f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3));
    assign split_wdata = wdata_q >> {cnt, 3'b000};

    // Aligned loads extend the live memory data; split loads extend the
    // bytes already gathered in rdata_q during the finishing SPLIT cycle.
    assign ext_raw = (state == ACCESS) ? mem_rdata : rdata_q;

    lsu_load_ext u_ext (
        .funct3 (f3_q),
        .raw    (ext_raw),
        .data   (ext_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = 3'b000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)          state_n = RESP;
                    else if (req_aligned) state_n = ACCESS;
                    else                  state_n = SPLIT;
                end
            end
            ACCESS: begin
                mem_read   = ~we_q;
                mem_write  = we_q;
                mem_funct3 = f3_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                state_n    = RESP;
            end
            SPLIT: begin
                if (done_q) begin
                    state_n = RESP;
                end else begin
                    mem_read   = ~we_q;
                    mem_write  = we_q;
                    mem_funct3 = we_q ? F3_B : F3_BU;
                    mem_addr   = addr_q + {30'h0, cnt};
                    mem_wdata  = {24'h0, split_wdata[7:0]};
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    end

    // NOTE: every register here is reset; there is no storage array, so a
    // reset abort leaves nothing stale for the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            cnt     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_bad;
                        rdata_q <= 32'h0;
                        cnt     <= 2'd0;
                        done_q  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!we_q) rdata_q <= ext_data;
                end
                SPLIT: begin
                    if (!done_q) begin
                        if (!we_q) rdata_q[{cnt, 3'b000} +: 8] <= mem_rdata[7:0];
                        if (last_byte) done_q <= 1'b1;
                        else           cnt    <= cnt + 2'd1;
                    end else if (!we_q) begin
                        rdata_q <= ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl. Two instances (split and error-on-misalign)
// share the request inputs and a byte-array data memory; only the selected
// instance sees req_valid, and idle outputs are zero so they are OR-merged.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] mem_rdata;

    logic        rdy1, rdy0, rv1, rv0, re1, re0, mr1, mr0, mw1, mw0;
    logic [2:0]  mf1, mf0;
    logic [31:0] rd1, rd0, ma1, ma0, md1, md0;

    logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;

    assign req_ready  = sel ? rdy1 : rdy0;
    assign rsp_valid  = rv1 | rv0;
    assign rsp_err    = re1 | re0;
    assign rsp_rdata  = rd1 | rd0;
    assign mem_read   = mr1 | mr0;
    assign mem_write  = mw1 | mw0;
    assign mem_funct3 = mf1 | mf0;
    assign mem_addr   = ma1 | ma0;
    assign mem_wdata  = md1 | md0;

    lsu_ctrl #(.MISALIGN_SPLIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .mem_read(mr1), .mem_write(mw1),
        .mem_funct3(mf1), .mem_addr(ma1), .mem_wdata(md1), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.MISALIGN_SPLIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy0),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0), .mem_read(mr0), .mem_write(mw0),
        .mem_funct3(mf0), .mem_addr(ma0), .mem_wdata(md0), .mem_rdata(mem_rdata)
    );

    // Data memory: 1 KiB, address modulo 1024; reads return the four bytes
    // starting at mem_addr, so unused upper bytes carry neighbouring data.
    logic [7:0] mem [1024];
    assign mem_rdata = {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                        mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < (1 << mem_funct3[1:0]); i++)
                mem[mem_addr[9:0] + 10'(i)] <= mem_wdata[8*i +: 8];
        end
    end

    // Reference model state and scoreboards.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } rsp_t;
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        byte_only;
    } op_t;

    logic [7:0]  ref_mem [1024];
    rsp_t        exp_rsp[$];
    op_t         exp_op[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] ai;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ai = a + 32'(i);
            w[8*i +: 8] = ref_mem[ai[9:0]];
        end
        case (f3)
            F3_B:    return 32'($signed(w[7:0]));
            F3_H:    return 32'($signed(w[15:0]));
            F3_BU:   return w & 32'h0000_00FF;
            F3_HU:   return w & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // Issue one request and predict its memory traffic and response.
    // lim caps the number of split bytes predicted (reset-abort case).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit predict, input int lim);
        int          n, k;
        logic        ill, ali;
        logic [31:0] ai;
        rsp_t        r;
        op_t         o;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            check("req_ready wait", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        n   = 1 << f3[1:0];
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        ali = (a % 32'(n)) == 32'h0;
        r.rdata = 32'h0;
        r.err   = 1'b0;
        if (ill || (!ali && !sel)) begin
            r.err = 1'b1;
            r.cyc = cyc + 1;
        end else if (ali) begin
            r.cyc = cyc + 2;
            o = '{we, f3, a, d, 1'b0};
            exp_op.push_back(o);
        end else begin
            r.cyc = cyc + 32'(n) + 2;
            for (int i = 0; i < n && i < lim; i++) begin
                o = '{we, (we ? F3_B : F3_BU), a + 32'(i), d >> (8*i), 1'b1};
                exp_op.push_back(o);
            end
        end
        if (!r.err) begin
            if (we) begin
                for (int i = 0; i < n && i < lim; i++) begin
                    ai = a + 32'(i);
                    ref_mem[ai[9:0]] = d[8*i +: 8];
                end
            end else begin
                r.rdata = ref_load(f3, a);
            end
        end
        if (predict) exp_rsp.push_back(r);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (exp_rsp.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, " pending rsp"}, 32'(exp_rsp.size()), 32'd0);
        check({name, " pending mem ops"}, 32'(exp_op.size()), 32'd0);
        exp_rsp.delete();
        exp_op.delete();
    endtask

    // Monitor: compares every memory strobe and every response as it appears.
    initial begin
        op_t  o;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                check("strobe exclusive", 32'(mem_read & mem_write), 32'd0);
                if (exp_op.size() == 0) begin
                    check("unexpected mem strobe", 32'd1, 32'd0);
                end else begin
                    o = exp_op.pop_front();
                    check("mem_write", 32'(mem_write), 32'(o.we));
                    check("mem_funct3", 32'(mem_funct3), 32'(o.f3));
                    check("mem_addr", mem_addr, o.addr);
                    if (o.we) begin
                        if (o.byte_only) check("mem_wdata byte", {24'h0, mem_wdata[7:0]}, {24'h0, o.wdata[7:0]});
                        else             check("mem_wdata", mem_wdata, o.wdata);
                    end
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected rsp_valid", 32'd1, 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(r.err));
                    check("rsp cycle", cyc, r.cyc);
                end
            end else begin
                check("rsp_err idle", 32'(rsp_err), 32'd0);
            end
            if (rst_n && (req_ready || rsp_valid))
                check("mem bus quiet", mem_addr | mem_wdata | {29'h0, mem_funct3} |
                      {31'h0, mem_read | mem_write}, 32'h0);
        end
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        sel        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        repeat (3) @(negedge clk);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset mem strobes", 32'({mem_read, mem_write}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset split", 32'(rdy1), 32'd1);
        check("ready after reset nosplit", 32'(rdy0), 32'd1);

        // Aligned word store/load round trip.
        issue(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 1, 4); wait_done("sw");
        issue(1'b0, F3_W, 32'h100, 32'h0, 1, 4);        wait_done("lw");

        // Sub-word loads with sign/zero extension.
        issue(1'b1, F3_W,  32'h100, 32'h12348056, 1, 4); wait_done("sw2");
        issue(1'b0, F3_B,  32'h101, 32'h0, 1, 4);        wait_done("lb");
        issue(1'b0, F3_BU, 32'h101, 32'h0, 1, 4);        wait_done("lbu");
        issue(1'b0, F3_HU, 32'h102, 32'h0, 1, 4);        wait_done("lhu");
        issue(1'b0, F3_H,  32'h100, 32'h0, 1, 4);        wait_done("lh");

        // Misaligned split store and load.
        issue(1'b1, F3_W, 32'h103, 32'hAABBCCDD, 1, 4); wait_done("split sw");
        issue(1'b0, F3_W, 32'h103, 32'h0, 1, 4);        wait_done("split lw");
        issue(1'b0, F3_H, 32'h105, 32'h0, 1, 4);        wait_done("split lh");
        issue(1'b0, F3_HU, 32'h103, 32'h0, 1, 4);       wait_done("split lhu");

        // Split across the top of the address space.
        issue(1'b1, F3_W, 32'hFFFF_FFFE, 32'h8765_4321, 1, 4); wait_done("wrap sw");
        issue(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, 1, 4);         wait_done("wrap lw");
        issue(1'b0, F3_H, 32'hFFFF_FFFF, 32'h0, 1, 4);         wait_done("wrap lh");

        // Illegal encodings on both instances, misaligned errors without split.
        issue(1'b0, 3'b011, 32'h100, 32'h0, 1, 4); wait_done("ld f3 011");
        issue(1'b1, 3'b100, 32'h100, 32'h5, 1, 4); wait_done("st f3 100");
        sel = 1'b0;
        issue(1'b0, F3_H, 32'h0FF, 32'h0, 1, 4);   wait_done("nosplit lh");
        issue(1'b1, F3_W, 32'h102, 32'h1, 1, 4);   wait_done("nosplit sw");
        issue(1'b0, 3'b111, 32'h100, 32'h0, 1, 4); wait_done("nosplit ld f3 111");
        issue(1'b0, F3_W, 32'h100, 32'h0, 1, 4);   wait_done("nosplit lw");

        // Reset two bytes into a split store.
        sel = 1'b1;
        issue(1'b1, F3_W, 32'h0FE, 32'h11223344, 0, 2);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort rsp", {30'h0, rsp_valid, rsp_err} | rsp_rdata, 32'h0);
        check("abort mem cmd", {29'h0, mem_funct3} | mem_addr | mem_wdata |
              {31'h0, mem_read | mem_write}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after abort", 32'(req_ready), 32'd1);
        check("abort bytes written", 32'(exp_op.size()), 32'd0);
        exp_op.delete();
        issue(1'b0, F3_HU, 32'h0FE, 32'h0, 1, 4); wait_done("abort lhu 0fe");
        issue(1'b0, F3_W,  32'h100, 32'h0, 1, 4); wait_done("abort lw 100");

        // Randomized mix on both instances.
        for (int t = 0; t < 400; t++) begin
            sel = 1'($urandom);
            we  = 1'($urandom);
            f3  = 3'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? $urandom : (32'h200 + 32'($urandom_range(0, 63)));
            issue(we, f3, a, $urandom, 1, 4);
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
